// File: rtl/tl_c_beat_sender_pkg.sv
// tl_c_beat_sender_pkg: TileLink C/D opcodes, permission params and beat-count helpers.
package tl_c_beat_sender_pkg;
  localparam logic [2:0] C_PROBE_ACK      = 3'd4;
  localparam logic [2:0] C_PROBE_ACK_DATA = 3'd5;
  localparam logic [2:0] C_RELEASE        = 3'd6;
  localparam logic [2:0] C_RELEASE_DATA   = 3'd7;
  localparam logic [2:0] D_RELEASE_ACK    = 3'd6;
  localparam logic [2:0] SHRINK_TTOB = 3'd0;
  localparam logic [2:0] SHRINK_TTON = 3'd1;
  localparam logic [2:0] SHRINK_BTON = 3'd2;
  localparam logic [2:0] REPORT_TTOT = 3'd3;
  localparam logic [2:0] REPORT_BTOB = 3'd4;
  localparam logic [2:0] REPORT_NTON = 3'd5;
  localparam int BEAT_BYTES = 16;
  localparam int MAX_BEATS  = 4;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;
  function automatic logic hasDataC(input logic [2:0] opcode);
    return opcode[0];
  endfunction
  // Sizes beyond one block saturate; sub-beat sizes still occupy a full beat.
  function automatic int numBeats(input int size, input int beat_log, input int block_log);
    int s;
    s = size > block_log ? block_log : size;
    return s <= beat_log ? 1 : 1 << (s - beat_log);
  endfunction
endpackage

// File: rtl/tl_c_beat_sender_if.sv
// tl_c_beat_sender_if: request, data, C and D channel bundle for the C-beat sender.
interface tl_c_beat_sender_if #(
  parameter int DATA_BITS   = 128,
  parameter int ADDR_BITS   = 32,
  parameter int SOURCE_BITS = 4,
  parameter int SIZE_BITS   = 4
);
  logic                   req_valid, req_ready;
  logic [2:0]             req_opcode, req_param;
  logic [SIZE_BITS-1:0]   req_size;
  logic [SOURCE_BITS-1:0] req_source;
  logic [ADDR_BITS-1:0]   req_address;
  logic                   dat_valid, dat_ready;
  logic [DATA_BITS-1:0]   dat_data;
  logic                   dat_corrupt;
  logic                   c_valid, c_ready;
  logic [2:0]             c_opcode, c_param;
  logic [SIZE_BITS-1:0]   c_size;
  logic [SOURCE_BITS-1:0] c_source;
  logic [ADDR_BITS-1:0]   c_address;
  logic [DATA_BITS-1:0]   c_data;
  logic                   c_corrupt;
  logic                   d_valid, d_ready;
  logic [2:0]             d_opcode;
  logic [SOURCE_BITS-1:0] d_source;
  logic                   busy, release_done;
  modport slave (
    input  req_valid, req_opcode, req_param, req_size, req_source, req_address,
           dat_valid, dat_data, dat_corrupt, c_ready, d_valid, d_opcode, d_source,
    output req_ready, dat_ready, c_valid, c_opcode, c_param, c_size, c_source,
           c_address, c_data, c_corrupt, d_ready, busy, release_done
  );
  modport master (
    output req_valid, req_opcode, req_param, req_size, req_source, req_address,
           dat_valid, dat_data, dat_corrupt, c_ready, d_valid, d_opcode, d_source,
    input  req_ready, dat_ready, c_valid, c_opcode, c_param, c_size, c_source,
           c_address, c_data, c_corrupt, d_ready, busy, release_done
  );
endinterface

// File: rtl/tl_beat_counter.sv
// tl_beat_counter: beat index counter with clear, increment-on-fire and last-beat flag.
module tl_beat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_last_idx,
  output logic [W-1:0] o_count,
  output logic         o_last
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk)
    if (rst || i_clr) r_count <= '0;
    else if (i_inc) r_count <= r_count + 1'b1;
  assign o_count = r_count;
  assign o_last  = r_count == i_last_idx;
endmodule

// File: rtl/tl_c_beat_sender.sv
// tl_c_beat_sender: streams one C-channel message per request and waits for ReleaseAck on D.
module tl_c_beat_sender
  import tl_c_beat_sender_pkg::*;
#(
  parameter int DATA_BITS   = 128,
  parameter int ADDR_BITS   = 32,
  parameter int SOURCE_BITS = 4,
  parameter int SIZE_BITS   = 4,
  parameter int BLOCK_BYTES = 64
) (
  input logic clock,
  input logic reset,
  tl_c_beat_sender_if.slave bus
);
  localparam int LOG_BEAT  = $clog2(DATA_BITS / 8);
  localparam int LOG_BLOCK = $clog2(BLOCK_BYTES);
  localparam int MAXB      = numBeats(LOG_BLOCK, LOG_BEAT, LOG_BLOCK);
  localparam int CW        = MAXB > 1 ? $clog2(MAXB) : 1;
  state_t                 r_state;
  logic                   r_req_ready, r_busy;
  logic [2:0]             r_opcode, r_param;
  logic [SIZE_BITS-1:0]   r_size;
  logic [SOURCE_BITS-1:0] r_source;
  logic [ADDR_BITS-1:0]   r_address;
  logic                   w_req_fire, w_send, w_data, w_c_fire, w_last, w_d_fire;
  logic [CW-1:0]          w_last_idx, w_count;
  assign w_req_fire = bus.req_valid && r_req_ready;
  assign w_send     = r_state == SEND;
  assign w_data     = hasDataC(r_opcode);
  assign w_last_idx = w_data ? CW'(numBeats(int'(r_size), LOG_BEAT, LOG_BLOCK) - 1) : '0;
  assign w_c_fire   = bus.c_valid && bus.c_ready;
  assign w_d_fire   = r_state == WAIT_ACK && bus.d_valid && bus.d_opcode == D_RELEASE_ACK &&
                      bus.d_source == r_source;
  tl_beat_counter #(.W(CW)) u_cnt (
    .clk(clock), .rst(reset), .i_clr(w_req_fire), .i_inc(w_c_fire),
    .i_last_idx(w_last_idx), .o_count(w_count), .o_last(w_last)
  );
  always_ff @(posedge clock)
    if (reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_opcode    <= '0;
      r_param     <= '0;
      r_size      <= '0;
      r_source    <= '0;
      r_address   <= '0;
    end else
      case (r_state)
        IDLE: if (w_req_fire) begin
          r_state     <= SEND;
          r_req_ready <= 1'b0;
          r_busy      <= 1'b1;
          r_opcode    <= bus.req_opcode;
          r_param     <= bus.req_param;
          r_size      <= bus.req_size;
          r_source    <= bus.req_source;
          r_address   <= bus.req_address;
        end
        SEND: if (w_c_fire && w_last) begin
          r_state     <= r_opcode[1] ? WAIT_ACK : IDLE;
          r_req_ready <= !r_opcode[1];
          r_busy      <= r_opcode[1];
        end
        WAIT_ACK: if (w_d_fire) begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
  assign bus.req_ready    = r_req_ready;
  assign bus.busy         = r_busy;
  assign bus.c_valid      = w_send && (w_data ? bus.dat_valid : 1'b1);
  assign bus.dat_ready    = w_send && w_data && bus.c_ready;
  assign bus.c_data       = w_send && w_data ? bus.dat_data : '0;
  assign bus.c_corrupt    = w_send && w_data && bus.dat_corrupt;
  assign bus.c_opcode     = r_opcode;
  assign bus.c_param      = r_param;
  assign bus.c_size       = r_size;
  assign bus.c_source     = r_source;
  assign bus.c_address    = r_address;
  assign bus.d_ready      = w_d_fire;
  assign bus.release_done = w_d_fire;
  logic w_unused;
  assign w_unused = ^w_count;
endmodule

// File: tb/tb_tl_c_beat_sender.sv
// tb_tl_c_beat_sender: directed vectors for the C-channel beat sender.
module tb_tl_c_beat_sender;
  import tl_c_beat_sender_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  tl_c_beat_sender_if bus ();
  tl_c_beat_sender dut (.clock(clk), .reset(rst), .bus(bus));

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [2:0] prm, input logic [3:0] sz,
                     input logic [3:0] src, input logic [31:0] addr);
    bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_param = prm;
    bus.req_size = sz; bus.req_source = src; bus.req_address = addr;
  endtask

  task automatic send_msg(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr,
                          input int exp_beats);
    int beats = 0;
    @(negedge clk); req(op, REPORT_NTON, sz, 4'd1, addr);
    bus.c_ready = 1'b1; bus.dat_valid = 1'b1;
    @(negedge clk); bus.req_valid = 1'b0;
    for (int t = 0; t < 10 && bus.busy; t++) begin
      bus.dat_data = {96'h0, addr ^ t};
      #1;
      if (bus.c_valid && bus.c_ready) begin
        beats++;
        check("msg_addr", bus.c_address, addr);
        check("msg_data", bus.c_data, op[0] ? {96'h0, addr ^ t} : 128'h0);
      end
      @(negedge clk);
    end
    check("msg_beats", beats, exp_beats);
    check("msg_idle_ready", bus.req_ready, 1);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_opcode = 0; bus.req_param = 0; bus.req_size = 0;
    bus.req_source = 0; bus.req_address = 0; bus.dat_valid = 0; bus.dat_data = 0;
    bus.dat_corrupt = 0; bus.c_ready = 0; bus.d_valid = 0; bus.d_opcode = 0; bus.d_source = 0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_c_valid", bus.c_valid, 0);
    check("rst_dat_ready", bus.dat_ready, 0);
    check("rst_d_ready", bus.d_ready, 0);
    check("rst_done", bus.release_done, 0);
    check("rst_c_addr", bus.c_address, 0);
    check("rst_c_data", bus.c_data, 0);
    rst = 1'b0;
    // ReleaseData, 4 beats, then D source mismatch then match
    req(C_RELEASE_DATA, SHRINK_TTON, 4'd6, 4'd3, 32'h8000_0040);
    bus.c_ready = 1'b1; bus.dat_valid = 1'b1; bus.dat_corrupt = 1'b1;
    #1 check("rd_idle_cvalid", bus.c_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.req_valid = 1'b0; bus.dat_data = 128'hA0 + i; bus.dat_corrupt = i[0];
      #1;
      check("rd_c_valid", bus.c_valid, 1);
      check("rd_c_data", bus.c_data, 128'hA0 + i);
      check("rd_c_corrupt", bus.c_corrupt, i[0]);
      check("rd_c_addr", bus.c_address, 32'h8000_0040);
      check("rd_c_hdr", {bus.c_opcode, bus.c_param, bus.c_size, bus.c_source}, {3'd7, 3'd1, 4'd6, 4'd3});
      check("rd_dat_ready", bus.dat_ready, 1);
      check("rd_busy", bus.busy, 1);
      check("rd_req_ready", bus.req_ready, 0);
    end
    @(negedge clk); bus.dat_valid = 1'b0; bus.dat_corrupt = 1'b0;
    bus.d_valid = 1'b1; bus.d_opcode = D_RELEASE_ACK; bus.d_source = 4'd2;
    #1;
    check("wa_c_valid", bus.c_valid, 0);
    check("wa_busy", bus.busy, 1);
    check("wa_bad_src_ready", bus.d_ready, 0);
    check("wa_bad_src_done", bus.release_done, 0);
    @(negedge clk); bus.d_opcode = 3'd4; bus.d_source = 4'd3;
    #1 check("wa_bad_op_ready", bus.d_ready, 0);
    @(negedge clk); bus.d_opcode = D_RELEASE_ACK;
    #1;
    check("wa_held_busy", bus.busy, 1);
    check("wa_ack_ready", bus.d_ready, 1);
    check("wa_ack_done", bus.release_done, 1);
    check("wa_req_ready", bus.req_ready, 0);
    @(negedge clk); bus.d_valid = 1'b0;
    #1;
    check("ack_done_pulse", bus.release_done, 0);
    check("ack_req_ready", bus.req_ready, 1);
    check("ack_busy", bus.busy, 0);
    // ProbeAck without data
    req(C_PROBE_ACK, REPORT_NTON, 4'd6, 4'd1, 32'h100);
    bus.dat_valid = 1'b1; bus.dat_data = 128'hFFFF;
    @(negedge clk); bus.req_valid = 1'b0;
    #1;
    check("pa_c_valid", bus.c_valid, 1);
    check("pa_c_data", bus.c_data, 0);
    check("pa_dat_ready", bus.dat_ready, 0);
    check("pa_hdr", {bus.c_opcode, bus.c_param}, {3'd4, 3'd5});
    @(negedge clk); bus.dat_valid = 1'b0;
    #1;
    check("pa_busy", bus.busy, 0);
    check("pa_c_valid_after", bus.c_valid, 0);
    check("pa_req_ready", bus.req_ready, 1);
    // ProbeAckData with C backpressure 1,0,0,1,1,1
    begin
      logic [5:0] pat = 6'b111001;
      int k = 0;
      req(C_PROBE_ACK_DATA, REPORT_TTOT, 4'd6, 4'd2, 32'h200);
      @(negedge clk); bus.req_valid = 1'b0; bus.dat_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (i > 0) @(negedge clk);
        bus.c_ready = pat[i]; bus.dat_data = 128'hB0 + k;
        #1;
        check("bp_c_valid", bus.c_valid, 1);
        check("bp_c_data", bus.c_data, 128'hB0 + k);
        check("bp_dat_ready", bus.dat_ready, pat[i]);
        if (pat[i]) k++;
      end
      @(negedge clk); bus.dat_valid = 1'b0; bus.c_ready = 1'b1;
      #1;
      check("bp_beats", k, 4);
      check("bp_busy", bus.busy, 0);
      check("bp_req_ready", bus.req_ready, 1);
    end
    // Beat counts for short, mid and oversized ProbeAckData, plus a plain ProbeAck
    send_msg(C_PROBE_ACK_DATA, 4'd4, 32'h300, 1);
    send_msg(C_PROBE_ACK_DATA, 4'd3, 32'h340, 1);
    send_msg(C_PROBE_ACK_DATA, 4'd5, 32'h380, 2);
    send_msg(C_PROBE_ACK_DATA, 4'd7, 32'h400, 4);
    send_msg(C_PROBE_ACK, 4'd6, 32'h440, 1);
    // Reset after beat 2 of a ReleaseData
    @(negedge clk); req(C_RELEASE_DATA, SHRINK_TTOB, 4'd6, 4'd4, 32'h8000_0080);
    bus.dat_valid = 1'b1; bus.c_ready = 1'b1;
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
    #1 check("mr_beat2_valid", bus.c_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mr_c_valid", bus.c_valid, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_req_ready", bus.req_ready, 1);
    check("mr_done", bus.release_done, 0);
    check("mr_c_addr", bus.c_address, 0);
    rst = 1'b0; bus.dat_valid = 1'b0;
    send_msg(C_PROBE_ACK_DATA, 4'd6, 32'h500, 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tl_c_beat_sender.md
# tl_c_beat_sender

Multi-beat TileLink C-channel sender for the L1 data cache. It accepts one Release, ReleaseData, ProbeAck or ProbeAckData request at a time. It streams the message onto channel C, one beat per accepted data word, with the header held constant across all beats. For Release and ReleaseData it then waits on channel D for the matching ReleaseAck. It replaces the single-beat, mask-less message helpers with a parametrised, handshaked engine that sits between the cache writeback/probe unit and the C/D channel arbiters.

## Interface
Parameters:
- DATA_BITS, 128, C-channel data width; BEAT_BYTES = DATA_BITS/8.
- ADDR_BITS, 32, address width.
- SOURCE_BITS, 4, source ID width.
- SIZE_BITS, 4, log2-size field width.
- BLOCK_BYTES, 64, cache block size; largest legal transfer.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- req_valid / req_ready  in / out  1 / 1  request handshake.
- req_opcode  in  3  C opcode: 4 ProbeAck, 5 ProbeAckData, 6 Release, 7 ReleaseData.
- req_param  in  3  shrink or report permission.
- req_size  in  SIZE_BITS  log2 bytes.
- req_source  in  SOURCE_BITS  source ID.
- req_address  in  ADDR_BITS  block address.
- dat_valid / dat_ready  in / out  1 / 1  data-beat handshake from the data array.
- dat_data  in  DATA_BITS  beat payload.
- dat_corrupt  in  1  beat corrupt flag.
- c_valid / c_ready  out / in  1 / 1  channel C handshake.
- c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt  out  widths as above  channel C fields.
- d_valid / d_ready  in / out  1 / 1  channel D handshake.
- d_opcode, d_source  in  3, SOURCE_BITS  channel D fields.
- busy  out  1  state != IDLE.
- release_done  out  1  one-cycle pulse when the ReleaseAck is consumed.

## Operation
- States are IDLE, SEND and WAIT_ACK.
- IDLE:
  - req_ready = 1.
  - On request fire, latch all req fields, clear the beat counter, go to SEND.
- Beat count:
  - hasData = opcode[0].
  - beats = hasData ? max(1, 2^size / BEAT_BYTES) : 1.
  - Sizes above log2(BLOCK_BYTES) saturate to BLOCK_BYTES/BEAT_BYTES beats.
- SEND with data:
  - c_valid = dat_valid; dat_ready = c_ready (combinational pass-through).
  - c_data and c_corrupt come from the dat_* inputs.
- SEND without data:
  - c_valid = 1; c_data = 0; c_corrupt = 0; dat_ready = 0.
- Beat advance:
  - A beat transfers when c_valid && c_ready; the counter increments.
  - On the last beat: Release/ReleaseData go to WAIT_ACK; ProbeAck/ProbeAckData go to IDLE.
- WAIT_ACK:
  - d_ready = d_valid && d_opcode == 6 (ReleaseAck) && d_source == latched source.
  - On that fire, pulse release_done and go to IDLE.
  - Non-matching D beats see d_ready = 0 and are left for other consumers.
- Header fields (opcode, param, size, source, address) are held constant on every beat.
- Reset in any state: after the reset edge, state = IDLE and all strobes are idle; an in-flight burst is abandoned.

## Timing
- Reset values:
  - req_ready = 1; busy = 0.
  - c_valid = 0; dat_ready = 0; d_ready = 0; release_done = 0.
  - c_* fields = 0.
- A request accepted at cycle N presents its first C beat at N+1.
- Throughput is one beat per cycle while dat_valid and c_ready stay high.
- A 4-beat ReleaseData occupies cycles N+1..N+4 and enters WAIT_ACK at N+5.
- release_done is asserted in the same cycle as the D fire. The next request can be accepted one cycle later.
- Minimum one-cycle bubble between messages; req_ready is never high outside IDLE.
- Under backpressure, c_valid must not drop once raised within a beat. The data source guarantees dat_valid stability.

## Structure
- Shared package (extend the existing TileLink edge/message package):
  - C/D opcode constants, shrink/report param constants.
  - hasDataC(opcode), numBeats(size) functions.
  - Localparams BEAT_BYTES and MAX_BEATS.
- One sub-module, tl_beat_counter:
  - Parametrised width; load/clear, increment-on-fire, last output.
  - Reusable for the A and D channels.

## Test plan
DATA_BITS=128, BLOCK_BYTES=64 (4 beats per block) throughout.

- **ReleaseData:** size 6, addr 0x8000_0040, source 3, param 1 (TtoN), c_ready=1 -> 4 consecutive beats, addr 0x8000_0040 on all beats, busy=1. Then D ReleaseAck source 3 -> release_done=1 for one cycle, req_ready=1 next cycle.
- **ProbeAck:** param 5 (NtoN) -> single beat, c_data=0, dat_ready=0, back to IDLE with no D wait.
- **Backpressure:** ProbeAckData size 6, c_ready pattern 1,0,0,1,1,1 -> beat 2 held stable across the stall, dat_ready=0 in stall cycles, 4 beats total.
- **D source match:** in WAIT_ACK, ReleaseAck with source 2 -> d_ready=0, state held. Then source 3 -> accepted.
- **Short ProbeAckData:** size 4 (16 bytes) -> exactly 1 beat, then IDLE.
- **Reset mid-burst:** reset asserted after beat 2 of a ReleaseData -> next cycle c_valid=0, busy=0, req_ready=1, no release_done.
